acc_alu_sequencer: RTL and testbench

- Command-side initiator for the 4-bit combinational ALU: it owns the accumulator register and issues each operation to the ALU.
- Accepts (op, operand) commands over a valid/ready handshake.
- Drives the ALU with a = accumulator and b = operand, captures the ALU result back into the accumulator, and returns the result and an error flag over a response handshake.
- Sits between the command source and the ALU instance in the accumulator datapath.

---
 rtl/acc_alu_sequencer.sv | 121 ++++++++++++
 tb/tb_acc_alu_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/acc_alu_sequencer.sv
// acc_alu_sequencer
//   Command-side initiator for the 4-bit combinational ALU. It owns the
//   accumulator, takes (op, operand) commands, issues ALU operations with
//   a = acc and b = operand, writes the ALU result back into acc and
//   returns it on a response handshake.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_operand    0-7 ALU select, 8 LOAD, 9 CLEAR, 10-15 illegal
//   alu_a, alu_b, alu_sel  registered drive to the ALU
//   alu_out                ALU result
//   rsp_valid/rsp_ready    response handshake (valid only in RESP)
//   rsp_acc, rsp_err       accumulator after the command, rejection flag
//   acc                    live accumulator
//   op_count               successful-command counter (wraps)
module acc_alu_sequencer #(
    parameter int         WIDTH    = 4,
    parameter int         CNT_W    = 8,
    parameter logic [3:0] PARK_SEL = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, RESP} state_t;

    state_t     state;
    logic [2:0] op_q;   // only the ALU select bits matter after decode

    // Handshake flags are pure decodes of the state register.
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            op_count <= '0;
            rsp_err  <= 1'b0;
            rsp_acc  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= PARK_SEL;
            op_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op[2:0];
                        if (!cmd_op[3]) begin
                            if (cmd_op[2:0] == 3'd3 && cmd_operand == '0) begin
                                // divide by zero: rejected without touching the ALU
                                rsp_err <= 1'b1;
                                rsp_acc <= acc;
                                state   <= RESP;
                            end else begin
                                // alu_b doubles as the latched operand; it is
                                // only written for real ALU issues so the ALU
                                // ports otherwise hold their last values.
                                alu_a <= acc;
                                alu_b <= cmd_operand;
                                state <= SETUP;
                            end
                        end else if (cmd_op == 4'd8) begin
                            acc     <= cmd_operand;
                            rsp_acc <= cmd_operand;
                            rsp_err <= 1'b0;
                            state   <= RESP;
                        end else if (cmd_op == 4'd9) begin
                            acc     <= '0;
                            rsp_acc <= '0;
                            rsp_err <= 1'b0;
                            state   <= RESP;
                        end else begin
                            rsp_err <= 1'b1;
                            rsp_acc <= acc;
                            state   <= RESP;
                        end
                    end
                end
                SETUP: begin
                    // Select stays parked this cycle so the move to the real
                    // op in EXEC is always a select change, which is what
                    // makes the ALU re-evaluate (even for a repeated op).
                    alu_sel <= {1'b0, op_q};
                    state   <= EXEC;
                end
                EXEC: begin
                    acc     <= alu_out;
                    rsp_acc <= alu_out;
                    rsp_err <= 1'b0;
                    alu_sel <= PARK_SEL;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (!rsp_err) op_count <= op_count + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_alu_sequencer.sv
module tb_acc_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_operand;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic [3:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_acc;
    logic       rsp_err;
    logic [3:0] acc;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    acc_alu_sequencer #(.WIDTH(4), .CNT_W(8), .PARK_SEL(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_acc(rsp_acc), .rsp_err(rsp_err),
        .acc(acc), .op_count(op_count)
    );

    // ALU model: re-evaluates only when the select changes.
    initial alu_out = 4'h0;
    always @(alu_sel) begin
        case (alu_sel)
            4'd0:    alu_out = alu_a + alu_b;
            4'd1:    alu_out = alu_a - alu_b;
            4'd2:    alu_out = 4'(alu_a * alu_b);
            4'd3:    alu_out = (alu_b != 4'd0) ? alu_a / alu_b : 4'h0;
            4'd4:    alu_out = {3'b000, (alu_a != 4'd0) && (alu_b != 4'd0)};
            4'd5:    alu_out = {3'b000, (alu_a != 4'd0) || (alu_b != 4'd0)};
            4'd6:    alu_out = alu_a ^ alu_b;
            4'd7:    alu_out = ~alu_a;
            default: alu_out = 4'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command, wait for its accept edge, then follow it to RESP,
    // checking latency, the alu_sel trace and the response fields.
    task automatic issue(input string tag, input logic [3:0] op, input logic [3:0] opnd,
                         input logic [3:0] eacc, input logic eerr);
        int n;
        int lat;
        logic is_alu;
        logic [3:0] tr [$];
        is_alu = (op < 4'd8) && !(op == 4'd3 && opnd == 4'd0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        tr.push_back(alu_sel);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); lat++; tr.push_back(alu_sel);
        end
        chk({tag, ".lat"}, 32'(lat), is_alu ? 32'd3 : 32'd1);
        if (is_alu && tr.size() == 3)
            chk({tag, ".seltrace"}, 32'({tr[0], tr[1], tr[2]}), 32'({4'hF, op, 4'hF}));
        else
            chk({tag, ".selpark"}, 32'(tr[0]), 32'hF);
        chk({tag, ".rsp_acc"}, 32'(rsp_acc), 32'(eacc));
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(eerr));
        chk({tag, ".acc"}, 32'(acc), 32'(eacc));
        if (!eerr) exp_cnt++;
    endtask

    // Complete the response handshake and check we are back in IDLE.
    task automatic respond(input string tag);
        @(negedge clk); rsp_ready = 1'b1;
        @(negedge clk); rsp_ready = 1'b0;
        chk({tag, ".idle"}, 32'({rsp_valid, cmd_ready}), 32'b01);
        chk({tag, ".cnt"}, 32'(op_count), 32'(exp_cnt[7:0]));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 4'h0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.acc", 32'(acc), 32'd0);
        chk("rst.cnt", 32'(op_count), 32'd0);
        chk("rst.alu", 32'({alu_sel, alu_a, alu_b}), 32'h0F00);
        chk("rst.rsp", 32'({rsp_err, rsp_acc}), 32'd0);
        rst_n = 1'b1;

        issue("load9", 4'd8, 4'd9, 4'd9, 1'b0);  respond("load9");
        issue("add9",  4'd0, 4'd9, 4'd2, 1'b0);  respond("add9");

        issue("load6", 4'd8, 4'd6, 4'd6, 1'b0);  respond("load6");
        issue("mul3",  4'd2, 4'd3, 4'd2, 1'b0);  respond("mul3");
        issue("div0",  4'd3, 4'd0, 4'd2, 1'b1);  respond("div0");

        issue("load12", 4'd8, 4'd12, 4'd12, 1'b0); respond("load12");
        issue("sub5a",  4'd1, 4'd5,  4'd7,  1'b0); respond("sub5a");
        issue("sub5b",  4'd1, 4'd5,  4'd2,  1'b0); respond("sub5b");

        // Back-pressure: hold rsp_ready low with a competing LOAD 15 waiting.
        issue("add1", 4'd0, 4'd1, 4'd3, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_operand = 4'd15;
        for (int i = 0; i < 5; i++) begin
            chk("hold.state", 32'({rsp_valid, cmd_ready}), 32'b10);
            chk("hold.acc", 32'({rsp_acc, acc}), 32'h33);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold.idle", 32'(cmd_ready), 32'd1);
        chk("hold.cnt", 32'(op_count), 32'(exp_cnt[7:0]));
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_cnt++;
        chk("hold.accept", 32'({rsp_valid, rsp_acc}), 32'h1F);
        respond("load15");

        issue("ill12", 4'd12, 4'd3, 4'd15, 1'b1); respond("ill12");
        issue("clear", 4'd9,  4'd7, 4'd0,  1'b0); respond("clear");
        issue("load4", 4'd8,  4'd4, 4'd4,  1'b0); respond("load4");

        // Reset while an ADD is in EXEC.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_operand = 4'd1;
        @(negedge clk);            // SETUP
        cmd_valid = 1'b0;
        @(negedge clk);            // EXEC
        chk("abort.exec", 32'(alu_sel), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort.state", 32'({rsp_valid, cmd_ready}), 32'b01);
        chk("abort.acc", 32'(acc), 32'd0);
        chk("abort.cnt", 32'(op_count), 32'd0);
        chk("abort.sel", 32'(alu_sel), 32'hF);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1'b1;
            end
            chk("abort.norsp", 32'(seen), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
